// File: rtl/readout_scheduler.sv
// Round-robin readout scheduler: grants one frequency-counter channel at a time and
// serialises its measurement as a 3-byte packet (header, MSB, LSB) on a valid/ready stream.
module readout_scheduler #(
    parameter int PIXELS       = 8,
    parameter int COUNTER_BITS = 15,
    parameter int IDX_BITS     = 3
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           enable,
    input  logic [PIXELS-1:0]              meas_valid,
    input  logic [PIXELS*COUNTER_BITS-1:0] meas_data,
    output logic [PIXELS-1:0]              meas_ack,
    output logic [7:0]                     out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy
);

    typedef enum logic [1:0] {IDLE, HDR, MSB, LSB} state_t;

    localparam logic [IDX_BITS:0]   LP_PIXELS = (IDX_BITS+1)'(PIXELS);
    localparam logic [IDX_BITS-1:0] LP_LAST   = IDX_BITS'(PIXELS-1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDX_BITS-1:0]     r_rr_ptr;
    logic [IDX_BITS-1:0]     r_idx;
    logic [COUNTER_BITS-1:0] r_data;
    logic [7:0]              r_out_data;
    logic [7:0]              w_out_data_next;

    logic [PIXELS-1:0]       w_rot;
    logic [IDX_BITS-1:0]     w_offset;
    logic [IDX_BITS:0]       w_sum;
    logic [IDX_BITS-1:0]     w_grant_idx;
    logic                    w_found;
    logic                    w_grant;
    logic [15:0]             w_data16;
    logic [COUNTER_BITS-1:0] w_slice [PIXELS];

    // Requests rotated so that bit 0 is the channel at rr_ptr.
    assign w_rot = PIXELS'({meas_valid, meas_valid} >> r_rr_ptr);

    always_comb begin
        w_offset = '0;
        for (int k = PIXELS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_offset = IDX_BITS'(k);
            end
        end
    end

    assign w_found     = |w_rot;
    assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_grant_idx = (w_sum >= LP_PIXELS) ? IDX_BITS'(w_sum - LP_PIXELS) : w_sum[IDX_BITS-1:0];
    // Gating with RST_N keeps the ack quiet while reset is being held.
    assign w_grant     = (r_state == IDLE) && enable && RST_N && w_found;
    assign w_data16    = 16'(r_data);

    genvar gi;
    generate
        for (gi = 0; gi < PIXELS; gi++) begin : g_chan
            assign w_slice[gi]  = meas_data[gi*COUNTER_BITS +: COUNTER_BITS];
            assign meas_ack[gi] = w_grant && (w_grant_idx == IDX_BITS'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_out_data_next = r_out_data;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_next    = HDR;
                    w_out_data_next = {4'b1010, 1'b0, 3'(w_grant_idx)};
                end
            end
            HDR: begin
                if (out_ready) begin
                    w_state_next    = MSB;
                    w_out_data_next = w_data16[15:8];
                end
            end
            MSB: begin
                if (out_ready) begin
                    w_state_next    = LSB;
                    w_out_data_next = w_data16[7:0];
                end
            end
            LSB: begin
                if (out_ready) begin
                    w_state_next    = IDLE;
                    w_out_data_next = 8'h00;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_out_data_next = 8'h00;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_out_data <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_out_data <= w_out_data_next;
            if (w_grant) begin
                r_data <= w_slice[w_grant_idx];
                r_idx  <= w_grant_idx;
            end
            if (r_state == LSB && out_ready) begin
                r_rr_ptr <= (r_idx == LP_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = (r_state != IDLE);
    assign out_last  = (r_state == LSB);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_readout_scheduler.sv
// Directed bench for readout_scheduler: expected bytes and acks are queued as stimulus is
// applied and popped as the DUT hands them over.
module tb_readout_scheduler;

    localparam int P  = 8;
    localparam int CB = 15;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            enable = 1'b0;
    logic [P-1:0]    meas_valid = '0;
    logic [P*CB-1:0] meas_data = '0;
    logic            out_ready = 1'b1;
    logic [P-1:0]    meas_ack;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_last;
    logic            busy;

    readout_scheduler #(.PIXELS(P), .COUNTER_BITS(CB), .IDX_BITS(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .enable(enable),
        .meas_valid(meas_valid), .meas_data(meas_data), .meas_ack(meas_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0]   exp_q[$];
    logic [P-1:0] ack_q[$];
    logic [P-1:0] s_ack;
    logic         s_busy, s_valid, s_last;
    logic [7:0]   s_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge what the next rising edge will consume.
    task automatic cyc();
        logic [8:0]   e;
        logic [P-1:0] a;
        @(negedge CLK);
        s_ack = meas_ack; s_busy = busy; s_valid = out_valid; s_last = out_last; s_data = out_data;
        if (RST_N && out_valid && out_ready) begin
            $display("byte 0x%02h last=%0b", out_data, out_last);
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $error("FAIL unexpected_byte: observed=0x%02h expected=none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("byte", 32'({out_last, out_data}), 32'(e));
            end
        end
        if (RST_N && meas_ack != '0) begin
            $display("ack 0x%02h", meas_ack);
            if (ack_q.size() == 0) begin
                n_cmp++; n_err++;
                $error("FAIL unexpected_ack: observed=0x%02h expected=none", meas_ack);
            end else begin
                a = ack_q.pop_front();
                check("ack", 32'(meas_ack), 32'(a));
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic push_pkt(input int idx, input logic [15:0] d);
        ack_q.push_back(P'(1) << idx);
        exp_q.push_back({1'b0, 8'hA0 | 8'(idx)});
        exp_q.push_back({1'b0, d[15:8]});
        exp_q.push_back({1'b1, d[7:0]});
    endtask

    task automatic set_slice(input int i, input logic [CB-1:0] v);
        meas_data[i*CB +: CB] = v;
    endtask

    task automatic run_until_empty(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        check(tag, 32'(exp_q.size() + ack_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0; meas_valid = '0; enable = 1'b0; out_ready = 1'b1;
        exp_q.delete(); ack_q.delete();
        cyc(); cyc();
        RST_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;

        // Reset state
        do_reset();
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_last", 32'(s_last), 32'd0);
        check("rst_data", 32'(s_data), 32'd0);
        check("rst_ack", 32'(s_ack), 32'd0);

        // Single request on ch3
        set_slice(3, 15'h1234);
        meas_valid = 8'b0000_1000; enable = 1'b1;
        push_pkt(3, 16'h1234);
        cyc();
        check("single_ack", 32'(s_ack), 32'h08);
        meas_valid = '0;
        nb = 0;
        repeat (6) begin
            cyc();
            if (s_busy) nb++;
        end
        check("single_busy_cycles", 32'(nb), 32'd3);
        check("single_drain", 32'(exp_q.size() + ack_q.size()), 32'd0);

        // All channels valid continuously
        do_reset();
        for (int i = 0; i < P; i++) set_slice(i, CB'(i * 16'h0101));
        for (int i = 0; i < P; i++) push_pkt(i, 16'(i * 16'h0101));
        push_pkt(0, 16'h0000);
        meas_valid = '1; enable = 1'b1;
        run_until_empty("all_drain", 60);
        enable = 1'b0; meas_valid = '0;
        cyc();
        check("all_idle", 32'(s_busy), 32'd0);

        // Ch0 and ch5 alternate; pointer wrap from 6 must find ch0
        do_reset();
        set_slice(0, 15'h0A0A); set_slice(5, 15'h0505);
        push_pkt(0, 16'h0A0A); push_pkt(5, 16'h0505);
        push_pkt(0, 16'h0A0A); push_pkt(5, 16'h0505);
        meas_valid = 8'b0010_0001; enable = 1'b1;
        run_until_empty("alt_drain", 40);
        enable = 1'b0; meas_valid = '0;

        // Backpressure during MSB with meas_data changing
        do_reset();
        set_slice(1, 15'h5A3C);
        push_pkt(1, 16'h5A3C);
        meas_valid = 8'b0000_0010; enable = 1'b1;
        cyc();
        meas_valid = '0;
        cyc();
        out_ready = 1'b0;
        set_slice(1, 15'h7FFF);
        repeat (5) begin
            cyc();
            check("bp_valid", 32'(s_valid), 32'd1);
            check("bp_data", 32'(s_data), 32'h5A);
        end
        out_ready = 1'b1;
        run_until_empty("bp_drain", 10);

        // enable low with requests pending
        do_reset();
        set_slice(0, 15'h0042);
        meas_valid = '1; enable = 1'b0;
        repeat (4) begin
            cyc();
            check("dis_ack", 32'(s_ack), 32'd0);
            check("dis_busy", 32'(s_busy), 32'd0);
        end
        // enable dropped in HDR: packet completes, no further grant
        push_pkt(0, 16'h0042);
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        run_until_empty("dis_hdr_drain", 10);
        repeat (6) cyc();
        check("dis_after_busy", 32'(s_busy), 32'd0);
        check("dis_after_ack", 32'(s_ack), 32'd0);
        meas_valid = '0;

        // Reset during MSB; pointer must return to 0
        do_reset();
        set_slice(5, 15'h0555);
        push_pkt(5, 16'h0555);
        meas_valid = 8'b0010_0000; enable = 1'b1;
        cyc();
        meas_valid = '0;
        run_until_empty("pre_rst_drain", 10);
        set_slice(4, 15'h0444);
        ack_q.push_back(8'h10);
        exp_q.push_back({1'b0, 8'hA4});
        meas_valid = 8'b0001_0000;
        cyc();
        meas_valid = '0;
        cyc();
        RST_N = 1'b0;
        set_slice(2, 15'h0222); set_slice(6, 15'h0666);
        meas_valid = 8'b0100_0100;
        cyc();
        cyc();
        check("midrst_valid", 32'(s_valid), 32'd0);
        check("midrst_busy", 32'(s_busy), 32'd0);
        check("midrst_ack", 32'(s_ack), 32'd0);
        check("midrst_partial", 32'(exp_q.size() + ack_q.size()), 32'd0);
        RST_N = 1'b1;
        push_pkt(2, 16'h0222);
        cyc();
        meas_valid = '0;
        run_until_empty("post_rst_drain", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
